// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver
//   Initiator side of the ALU operand/result interface. Commands arrive on a
//   valid/ready port and are buffered in a small FIFO. Each is issued to the
//   registered ALU for one cycle, C is captured on the following cycle, and the
//   result is held on a valid/ready response port until it is consumed.
//   One command completes every 3 cycles at best.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op/cmd_a/cmd_b payload
//   rsp_valid/rsp_ready   response handshake; rsp_data/rsp_op payload
//   alu_reset             active-high ALU reset (combinational !reset)
//   alu_opcode/alu_A/alu_B registered ALU operands, idle values outside ISSUE
//   alu_C                 ALU result, valid the cycle after the operands
//   busy                  FSM active or FIFO non-empty
//   fifo_count            FIFO occupancy
//
// Optional build macro ALU_DRV_CHECK_EN adds rsp_err (ALU result differs from
// the locally computed reference) and err_count (saturating error tally).
module alu_cmd_driver #(
  parameter int unsigned    WIDTH   = 8,
  parameter int unsigned    OPW     = 3,
  parameter int unsigned    DEPTH   = 4,
  parameter logic [OPW-1:0] IDLE_OP = OPW'(3'b111)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OPW-1:0]           cmd_op,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [OPW-1:0]           rsp_op,
  output logic                     alu_reset,
  output logic [OPW-1:0]           alu_opcode,
  output logic [WIDTH-1:0]         alu_A,
  output logic [WIDTH-1:0]         alu_B,
  input  logic [WIDTH-1:0]         alu_C,
  output logic                     busy,
`ifdef ALU_DRV_CHECK_EN
  output logic                     rsp_err,
  output logic [15:0]              err_count,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = OPW + 2 * WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic             push, pop, fifo_empty;
  logic [OPW-1:0]   head_op;
  logic [WIDTH-1:0] head_a, head_b;

  logic [OPW-1:0]   alu_op_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [OPW-1:0]   iss_op_q;
  logic [WIDTH-1:0] iss_a_q, iss_b_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [OPW-1:0]   rsp_op_q;

  // Gated by reset so the source sees no ready while the block is held in reset.
  assign cmd_ready  = reset && (count_q != CW'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign fifo_empty = (count_q == '0);
  assign {head_op, head_a, head_b} = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP: begin
        // Handshake and the next pop share one edge to keep the 3-cycle cadence.
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      alu_op_q    <= IDLE_OP;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      iss_op_q    <= '0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

      // Operands are live only during ISSUE so an idle ALU always yields C=0.
      if (pop) begin
        alu_op_q <= head_op;
        alu_a_q  <= head_a;
        alu_b_q  <= head_b;
        iss_op_q <= head_op;
        iss_a_q  <= head_a;
        iss_b_q  <= head_b;
      end else if (state_q == S_ISSUE) begin
        alu_op_q <= IDLE_OP;
        alu_a_q  <= '0;
        alu_b_q  <= '0;
      end

      if (state_q == S_CAPTURE) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= alu_C;
        rsp_op_q    <= iss_op_q;
      end else if (state_q == S_RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_DRV_CHECK_EN
  logic        rsp_err_q;
  logic [15:0] err_cnt_q;

  function automatic logic [WIDTH-1:0] alu_ref(input logic [OPW-1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      OPW'(0): return a + b;
      OPW'(1): return a - b;
      OPW'(2): return ~a;
      OPW'(3): return {{(WIDTH-1){1'b0}}, |b};
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (state_q == S_CAPTURE) begin
        rsp_err_q <= (alu_C != alu_ref(iss_op_q, iss_a_q, iss_b_q));
      end
      if (state_q == S_RESP && rsp_ready && rsp_err_q && err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign rsp_err   = rsp_err_q;
  assign err_count = err_cnt_q;
`endif

  assign alu_reset  = !reset;
  assign alu_opcode = alu_op_q;
  assign alu_A      = alu_a_q;
  assign alu_B      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_op     = rsp_op_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

  localparam logic [2:0] IDLE_OP = 3'b111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [2:0] rsp_op;
  logic       alu_reset;
  logic [2:0] alu_opcode;
  logic [7:0] alu_A, alu_B, alu_C;
  logic       busy;
  logic [2:0] fifo_count;
`ifdef ALU_DRV_CHECK_EN
  logic        rsp_err;
  logic [15:0] err_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_cmd_driver #(.WIDTH(8), .OPW(3), .DEPTH(4), .IDLE_OP(IDLE_OP)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op),
    .alu_reset(alu_reset), .alu_opcode(alu_opcode),
    .alu_A(alu_A), .alu_B(alu_B), .alu_C(alu_C),
    .busy(busy),
`ifdef ALU_DRV_CHECK_EN
    .rsp_err(rsp_err), .err_count(err_count),
`endif
    .fifo_count(fifo_count)
  );

  // Stand-in for the registered ALU; force_c corrupts its output.
  logic       force_c = 1'b0;
  logic [7:0] c_q;

  function automatic logic [7:0] alu_model(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ~a;
      3'd3:    return (b != 8'd0) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  always @(posedge clk or posedge alu_reset) begin
    if (alu_reset) c_q <= 8'd0;
    else           c_q <= alu_model(alu_opcode, alu_A, alu_B);
  end
  assign alu_C = force_c ? 8'h55 : c_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge after the sampling edge.
  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic acc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    acc       = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [7:0] d, output logic [2:0] o, output int lat);
    d   = '0;
    o   = '0;
    lat = 0;
    repeat (30) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        d = rsp_data;
        o = rsp_op;
        return;
      end
    end
    lat = -1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic       acc;
    logic [7:0] d;
    logic [2:0] o;
    int         lat;
    logic       accs[6];
    logic [7:0] got_d[5];
    logic [7:0] exp_bp[5];
    int         got;
    int         stale;

    vecs[0] = '{3'd0, 8'd200, 8'd100, 8'd44};
    vecs[1] = '{3'd0, 8'd255, 8'd1,   8'd0};
    vecs[2] = '{3'd1, 8'd5,   8'd7,   8'hFE};
    vecs[3] = '{3'd1, 8'd0,   8'd1,   8'hFF};
    vecs[4] = '{3'd2, 8'h0F,  8'h00,  8'hF0};
    vecs[5] = '{3'd2, 8'h00,  8'h33,  8'hFF};
    vecs[6] = '{3'd3, 8'h00,  8'h00,  8'h00};
    vecs[7] = '{3'd3, 8'h5A,  8'h10,  8'h01};
    vecs[8] = '{3'd5, 8'd9,   8'd9,   8'h00};
    vecs[9] = '{3'd7, 8'hFF,  8'hFF,  8'h00};

    // Reset state
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_op", 32'(rsp_op), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_alu_reset", 32'(alu_reset), 32'd1);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'(IDLE_OP));
    chk("rst_alu_A", 32'(alu_A), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rel_alu_reset", 32'(alu_reset), 32'd0);

    // Single-command vectors with latency and operand-window checks
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].op, vecs[i].a, vecs[i].b, acc);
      chk("vec_accept", 32'(acc), 32'd1);
      lat = 0;
      repeat (20) begin
        @(negedge clk);
        lat++;
        if (lat == 1) begin
          chk("vec_issue_op", 32'(alu_opcode), 32'(vecs[i].op));
          chk("vec_issue_A", 32'(alu_A), 32'(vecs[i].a));
          chk("vec_issue_B", 32'(alu_B), 32'(vecs[i].b));
        end
        if (lat == 2) begin
          chk("vec_capture_op", 32'(alu_opcode), 32'(IDLE_OP));
          chk("vec_capture_A", 32'(alu_A), 32'd0);
        end
        if (rsp_valid) break;
      end
      chk("vec_latency", 32'(lat), 32'd3);
      chk("vec_rsp_data", 32'(rsp_data), 32'(vecs[i].exp));
      chk("vec_rsp_op", 32'(rsp_op), 32'(vecs[i].op));
      @(negedge clk);
      chk("vec_rsp_cleared", 32'(rsp_valid), 32'd0);
      chk("vec_idle_busy", 32'(busy), 32'd0);
      chk("vec_idle_op", 32'(alu_opcode), 32'(IDLE_OP));
    end

    // Back-to-back: next ISSUE on the same edge as the first handshake
    push(3'd1, 8'd5, 8'd7, acc);
    chk("b2b_accept0", 32'(acc), 32'd1);
    push(3'd2, 8'h0F, 8'h00, acc);
    chk("b2b_accept1", 32'(acc), 32'd1);
    get_rsp(d, o, lat);
    chk("b2b_rsp0", 32'(d), 32'hFE);
    chk("b2b_op0", 32'(o), 32'd1);
    @(negedge clk);
    chk("b2b_valid_drop", 32'(rsp_valid), 32'd0);
    chk("b2b_issue_op", 32'(alu_opcode), 32'd2);
    chk("b2b_issue_A", 32'(alu_A), 32'h0F);
    get_rsp(d, o, lat);
    chk("b2b_lat1", 32'(lat), 32'd2);
    chk("b2b_rsp1", 32'(d), 32'hF0);
    chk("b2b_op1", 32'(o), 32'd2);
    @(negedge clk);

    // Backpressure fills the FIFO
    rsp_ready = 1'b0;
    push(3'd0, 8'd1,   8'd2,   accs[0]);
    push(3'd1, 8'd10,  8'd3,   accs[1]);
    push(3'd2, 8'hAA,  8'h00,  accs[2]);
    push(3'd3, 8'h00,  8'h01,  accs[3]);
    push(3'd0, 8'h80,  8'h80,  accs[4]);
    push(3'd0, 8'd9,   8'd9,   accs[5]);
    for (int i = 0; i < 5; i++) chk("bp_accept", 32'(accs[i]), 32'd1);
    chk("bp_sixth_rejected", 32'(accs[5]), 32'd0);
    chk("bp_fifo_count", 32'(fifo_count), 32'd4);
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rsp_data", 32'(rsp_data), 32'd3);
    repeat (3) @(negedge clk);
    chk("bp_rsp_stable", 32'(rsp_data), 32'd3);
    chk("bp_valid_held", 32'(rsp_valid), 32'd1);
    chk("bp_count_held", 32'(fifo_count), 32'd4);
    exp_bp = '{8'd3, 8'd7, 8'h55, 8'd1, 8'd0};
    rsp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      if (rsp_valid) begin
        got_d[got] = rsp_data;
        got++;
      end
      @(negedge clk);
    end
    chk("bp_count_rsp", 32'(got), 32'd5);
    for (int i = 0; i < 5; i++) chk("bp_order", 32'(got_d[i]), 32'(exp_bp[i]));
    repeat (4) @(negedge clk);
    chk("bp_drained_count", 32'(fifo_count), 32'd0);
    chk("bp_drained_busy", 32'(busy), 32'd0);
    chk("bp_no_extra_rsp", 32'(rsp_valid), 32'd0);

    // Reset during CAPTURE with two commands queued
    push(3'd0, 8'd1, 8'd1, acc);
    push(3'd0, 8'd2, 8'd2, acc);
    push(3'd0, 8'd3, 8'd3, acc);
    chk("mid_queued", 32'(fifo_count), 32'd2);
    chk("mid_capture_op", 32'(alu_opcode), 32'(IDLE_OP));
    #1 reset = 1'b0;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_fifo_count", 32'(fifo_count), 32'd0);
    chk("mid_alu_reset", 32'(alu_reset), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("mid_no_stale", 32'(stale), 32'd0);
    chk("mid_busy_after", 32'(busy), 32'd0);
    push(3'd0, 8'd1, 8'd1, acc);
    get_rsp(d, o, lat);
    chk("mid_recover_lat", 32'(lat), 32'd3);
    chk("mid_recover_data", 32'(d), 32'd2);
    @(negedge clk);

`ifdef ALU_DRV_CHECK_EN
    force_c = 1'b1;
    push(3'd0, 8'd1, 8'd1, acc);
    get_rsp(d, o, lat);
    chk("chk_bad_data", 32'(d), 32'h55);
    chk("chk_err_set", 32'(rsp_err), 32'd1);
    @(negedge clk);
    chk("chk_err_count1", 32'(err_count), 32'd1);
    force_c = 1'b0;
    push(3'd0, 8'd1, 8'd1, acc);
    get_rsp(d, o, lat);
    chk("chk_good_data", 32'(d), 32'd2);
    chk("chk_err_clear", 32'(rsp_err), 32'd0);
    @(negedge clk);
    chk("chk_err_count_hold", 32'(err_count), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator side of the ALU operand/result interface: accepts commands on a valid/ready port, buffers them, drives opcode/A/B into the registered ALU, captures C one cycle later, and returns the result on a valid/ready response port.
- Sits between a command source (sequencer/CPU stub) and the ALU; owns the ALU reset.
- Throughput is one command per 3 cycles, with no response backpressure.

Parameters:
WIDTH, 8, width of operands A/B and result C (result truncated to WIDTH)
OPW, 3, opcode width; 0 add, 1 sub, 2 ~A, 3 |B, others yield C=0
DEPTH, 4, command FIFO entries (power of two, >=2)
IDLE_OP, 3'b111, opcode driven to the ALU when no command is issued

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low (0 = in reset)
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; equals (count != DEPTH)
cmd_op  in  OPW  command opcode
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
rsp_valid  out  1  result available; held until rsp_ready
rsp_ready  in  1  consumer accepts result
rsp_data  out  WIDTH  captured ALU result
rsp_op  out  OPW  opcode that produced rsp_data
alu_reset  out  1  active-high ALU reset; equals !reset (combinational)
alu_opcode  out  OPW  ALU opcode
alu_A  out  WIDTH  ALU operand A
alu_B  out  WIDTH  ALU operand B
alu_C  in  WIDTH  ALU registered result (valid the cycle after operands)
busy  out  1  FSM not in IDLE or FIFO not empty
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied, count=0, FSM=IDLE, rsp_valid=0, rsp_data=0, rsp_op=0.
  - alu_opcode=IDLE_OP, alu_A=0, alu_B=0, busy=0, cmd_ready=0 while reset low.
- Push occurs when cmd_valid && cmd_ready. cmd_ready depends only on registered count, so a push into a full FIFO never happens, even if a pop occurs in the same cycle.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- FSM (registered):
  - IDLE: if FIFO non-empty, pop head and go to ISSUE.
  - ISSUE (1 cycle): alu_opcode/alu_A/alu_B = popped command, registered outputs valid this cycle; go to CAPTURE.
  - CAPTURE (1 cycle): ALU presents C; latch rsp_data<=alu_C, rsp_op<=issued op, rsp_valid<=1; operands revert to IDLE_OP/0/0; go to RESP.
  - RESP: hold rsp_valid/rsp_data/rsp_op stable until rsp_ready=1. On handshake, clear rsp_valid; if FIFO non-empty, pop and go to ISSUE in the same edge, else go to IDLE.
- Latency: command accepted at edge N, earliest rsp_valid at edge N+3 (IDLE pop N+1, ISSUE N+2, CAPTURE latch N+3).
- ALU inputs equal IDLE_OP/0/0 in every state except ISSUE, so an idle ALU always outputs C=0.
- Opcodes >=4 are issued unchanged; the response carries whatever the ALU returns (expected 0).
- Arithmetic expectations, all modulo 2^WIDTH:
  - add: A+B
  - sub: A-B (two's complement)
  - ~A: bitwise
  - |B: zero-extended 1-bit reduction-OR
- Reset mid-operation: any in-flight command or pending response is discarded without a response; after release, the block starts in IDLE with an empty FIFO.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro ALU_DRV_CHECK_EN.
- Defined:
  - Adds output rsp_err (1 bit, reset 0).
  - In CAPTURE, compute the expected result from the issued op/A/B per the arithmetic rules above (0 for op>=4); rsp_err <= (alu_C != expected); held with rsp_valid.
  - Adds a saturating 16-bit err_count output (reset 0), incremented on each response handshake with rsp_err=1.
- Undefined: no rsp_err/err_count ports and no checker logic; all other behaviour identical.

Test Plan:
- Add wrap: WIDTH=8, push op0 A=200 B=100 with rsp_ready=1 -> rsp_valid exactly 3 edges after acceptance, rsp_data=44, rsp_op=0, alu_opcode=IDLE_OP outside ISSUE.
- Sub/NotA: push op1 A=5 B=7, then op2 A=0x0F -> responses in order 0xFE then 0xF0; second ISSUE immediately follows the first RESP handshake.
- Reduction-OR and default: push op3 B=0x00, op3 B=0x10, op5 A=9 B=9 -> rsp_data 0, 1, 0.
- Backpressure/full: rsp_ready=0, push 6 commands back-to-back with DEPTH=4 -> 1 in ISSUE/CAPTURE/RESP, FIFO fills to 4, cmd_ready=0, fifo_count=4, rsp_data stable. Then rsp_ready=1 -> all 5 accepted commands return in order; the 6th is never accepted while cmd_ready=0.
- Reset mid-flight: assert reset=0 during CAPTURE with 2 queued -> rsp_valid=0, fifo_count=0, alu_reset=1 immediately (asynchronous). After release, no stale response and busy=0.
- ALU_DRV_CHECK_EN: force alu_C=0x55 on an add 1+1 -> rsp_err=1, err_count=1 after handshake; correct add -> rsp_err=0.
